// File: rtl/icache_2way_lru.sv
// Two-way set-associative instruction cache with one LRU bit per set.
// Misses refill the whole line with one AXI INCR burst, then respond.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   pc_valid, pc_addr      - fetch request (byte address, bits[1:0] ignored)
//   instr_valid, instr_data- one-cycle response pulse and fetched word
//   ar*                    - AXI read address channel (line-aligned bursts)
//   r*                     - AXI read data channel (rresp ignored)
module icache_2way_lru #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 32,
  parameter int unsigned WAYS       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic              rlast,
  input  logic [1:0]        rresp
);

  localparam int unsigned BYTE_W   = $clog2(DATA_W / 8);
  localparam int unsigned OFF_W    = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W    = $clog2(SETS);
  localparam int unsigned LINE_LSB = OFF_W + BYTE_W;
  localparam int unsigned TAG_W    = ADDR_W - IDX_W - LINE_LSB;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP} state_e;

  // Storage arrays
  logic [DATA_W-1:0] data_q  [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]  tags_q  [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   lru_q;

  // Control registers
  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_lat_q, tag_lat_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              victim_q, victim_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;

  // Array write controls
  logic data_we_c, fill_we_c, lru_we_c, lru_val_c;
  logic hit0_c, hit1_c;

  logic unused_bits;
  assign unused_bits = ^{pc_addr[BYTE_W-1:0], rresp};

  assign hit0_c = valid_q[0][idx_q] && (tags_q[0][idx_q] == tag_lat_q);
  assign hit1_c = valid_q[1][idx_q] && (tags_q[1][idx_q] == tag_lat_q);

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    tag_lat_d     = tag_lat_q;
    idx_d         = idx_q;
    off_d         = off_q;
    victim_d      = victim_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    instr_valid_d = 1'b0;
    instr_data_d  = instr_data_q;
    araddr_d      = araddr_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    data_we_c     = 1'b0;
    fill_we_c     = 1'b0;
    lru_we_c      = 1'b0;
    lru_val_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pc_valid) begin
          tag_lat_d = pc_addr[ADDR_W-1:LINE_LSB+IDX_W];
          idx_d     = pc_addr[LINE_LSB+IDX_W-1:LINE_LSB];
          off_d     = pc_addr[LINE_LSB-1:BYTE_W];
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit0_c || hit1_c) begin
          instr_data_d  = data_q[hit1_c][idx_q][off_q];
          instr_valid_d = 1'b1;
          lru_we_c      = 1'b1;
          lru_val_c     = ~hit1_c;
          state_d       = RESP;
        end else begin
          // Fill an empty way first (way0 preferred), otherwise evict LRU
          if (!valid_q[0][idx_q])      victim_d = 1'b0;
          else if (!valid_q[1][idx_q]) victim_d = 1'b1;
          else                         victim_d = lru_q[idx_q];
          araddr_d  = {tag_lat_q, idx_q, {LINE_LSB{1'b0}}};
          arvalid_d = 1'b1;
          state_d   = REFILL_AR;
        end
      end
      REFILL_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = REFILL_R;
        end
      end
      REFILL_R: begin
        if (rvalid && rready_q) begin
          data_we_c = 1'b1;
          cnt_d     = cnt_q + OFF_W'(1);
          if (cnt_q == off_q) word_d = rdata;
          // rlast or a full line ends the burst
          if (rlast || (cnt_q == OFF_W'(LINE_WORDS - 1))) begin
            rready_d      = 1'b0;
            fill_we_c     = 1'b1;
            lru_we_c      = 1'b1;
            lru_val_c     = ~victim_q;
            instr_valid_d = 1'b1;
            instr_data_d  = (cnt_q == off_q) ? rdata : word_q;
            state_d       = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control register state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tag_lat_q     <= '0;
      idx_q         <= '0;
      off_q         <= '0;
      victim_q      <= 1'b0;
      cnt_q         <= '0;
      word_q        <= '0;
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tag_lat_q     <= tag_lat_d;
      idx_q         <= idx_d;
      off_q         <= off_d;
      victim_q      <= victim_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      instr_valid_q <= instr_valid_d;
      instr_data_q  <= instr_data_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
    end
  end

  // Data and tag arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (data_we_c) data_q[victim_q][idx_q][cnt_q] <= rdata;
    if (fill_we_c) tags_q[victim_q][idx_q] <= tag_lat_q;
  end

  // Valid and LRU bits; a line only becomes valid once its refill completes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < int'(WAYS); w++) valid_q[w] <= '0;
      lru_q <= '0;
    end else begin
      if (fill_we_c) valid_q[victim_q][idx_q] <= 1'b1;
      if (lru_we_c)  lru_q[idx_q] <= lru_val_c;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr_data  = instr_data_q;
  assign araddr      = araddr_q;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign arlen       = 8'(LINE_WORDS - 1);
  assign arsize      = 3'(BYTE_W);
  assign arburst     = 2'b01;

endmodule

// File: tb/tb_icache_2way_lru.sv
// Directed bench for icache_2way_lru: an AXI memory slave model feeds
// refills, and scoreboard queues hold expected instructions and AR addresses.
module tb_icache_2way_lru;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic [1:0]  rresp;

  icache_2way_lru dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_addr(pc_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ar_delay = 0;
  bit r_gaps = 1'b0;
  int ar_count = 0;
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] slv_addr;
  int slv_t;

  // Memory contents as a fixed scramble of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // AXI read slave: optional AR stall, optional gaps between beats
  initial begin
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst && arvalid) begin
        slv_addr = araddr;
        for (int d = 0; d < ar_delay; d++) begin
          @(negedge clk);
          check("arvalid_hold", 32'(arvalid), 32'd1);
          check("araddr_hold", araddr, slv_addr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("arlen", 32'(arlen), 32'd31);
        check("arsize", 32'(arsize), 32'd2);
        check("arburst", 32'(arburst), 32'd1);
        check("ar_expected", 32'(exp_ar_q.size() > 0), 32'd1);
        if (exp_ar_q.size() > 0) check("araddr", slv_addr, exp_ar_q.pop_front());
        ar_count++;
        for (int i = 0; i < 32; i++) begin
          if (r_gaps && (i % 7 == 3)) begin
            rvalid = 1'b0;
            repeat (2) @(negedge clk);
          end
          rvalid = 1'b1;
          rdata  = mem_word(slv_addr + 32'(i * 4));
          rlast  = (i == 31);
          slv_t  = 0;
          while (!rready && slv_t < 50) begin
            @(negedge clk);
            slv_t++;
          end
          @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
    end
  end

  // One fetch: push expectations, drop pc_valid after acceptance, await response
  task automatic req(input logic [31:0] addr, input bit exp_hit, input logic [31:0] exp_ar);
    int n;
    int ar0;
    logic [31:0] held;
    @(negedge clk);
    pc_valid = 1'b1;
    pc_addr  = addr;
    exp_data_q.push_back(mem_word({addr[31:2], 2'b00}));
    if (!exp_hit) exp_ar_q.push_back(exp_ar);
    ar0 = ar_count;
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
    pc_addr  = $urandom;
    n = 0;
    while (!instr_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("resp_seen", 32'(instr_valid), 32'd1);
    if (instr_valid) check("instr_data", instr_data, exp_data_q.pop_front());
    if (exp_hit) check("hit_latency", 32'(n), 32'd2);
    check("ar_count", 32'(ar_count - ar0), exp_hit ? 32'd0 : 32'd1);
    held = instr_data;
    @(negedge clk);
    check("pulse_width", 32'(instr_valid), 32'd0);
    check("data_hold", instr_data, held);
  endtask

  initial begin
    rst = 1'b1;
    pc_valid = 1'b0;
    pc_addr = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_ar", 32'(ar_count), 32'd0);
    check("idle_arvalid", 32'(arvalid), 32'd0);

    // Cold miss into way0 of set 1, then hit
    req(32'h0000_0088, 1'b0, 32'h0000_0080);
    req(32'h0000_0088, 1'b1, 32'h0);
    // Second tag fills way1; third tag evicts way0
    req(32'h0000_2088, 1'b0, 32'h0000_2080);
    req(32'h0000_4088, 1'b0, 32'h0000_4080);
    req(32'h0000_2088, 1'b1, 32'h0);
    // The hit made way0 (tag 2) least recent, so tag 0 replaces it
    req(32'h0000_0088, 1'b0, 32'h0000_0080);
    req(32'h0000_2088, 1'b1, 32'h0);
    req(32'h0000_4088, 1'b0, 32'h0000_4080);
    req(32'h0000_2088, 1'b1, 32'h0);

    // Stalled AR and gapped data; then every word of the line must hit
    ar_delay = 3;
    r_gaps   = 1'b1;
    req(32'h0001_0010, 1'b0, 32'h0001_0000);
    for (int i = 0; i < 32; i++) req(32'h0001_0000 + 32'(i * 4), 1'b1, 32'h0);

    // First and last word of a line requested on a miss; low bits ignored
    ar_delay = 1;
    r_gaps   = 1'b0;
    req(32'h0000_017F, 1'b0, 32'h0000_0100);
    req(32'h0000_8200, 1'b0, 32'h0000_8200);
    req(32'h0000_0103, 1'b1, 32'h0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_data_q.size() + exp_ar_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
